mod_execute_stage: RTL and testbench
====================================

// Module: mod_execute_stage
// PURPOSE
//  Execute stage between ID and mod_writeback. Accepts one decoded instruction per valid/ready handshake.
//  Computes single-cycle ALU results and multi-cycle unsigned MUL/DIV (opcode 0xF7 group).
//  Returns results in a registered EX_WB bundle consumed by the writeback stage.
//  Single pipeline slot: never more than one instruction in flight.
// PARAMETERS
//  XLEN       64   operand/result width in bits
//  MD_CNT_W   7    iteration counter width; must hold XLEN
// PORTS
//  clk            in   1       rising-edge clock
//  reset_n        in   1       asynchronous, active-low reset
//  idex_valid     in   1       upstream presents an instruction
//  idex_ready     out  1       stage accepts this cycle
//  idex           in   ID_EX   opcode[8], regByte[4], rmByte[4], modrm_reg[3], op_a, op_b, op_rdx, pc, sim_end
//  exwb_valid     out  1       exwb holds a completed result
//  exwb_ready     in   1       writeback consumes exwb this cycle
//  exwb           out  EX_WB   pc_contents, alu_result, alu_ext_result, ctl_opcode, ctl_regByte, ctl_rmByte, sim_end
//  busy           out  1       MUL/DIV iteration in progress
//  div_fault      out  1       valid with exwb_valid; DIV by zero or quotient overflow
// BEHAVIOUR
//  Reset (async, reset_n=0)
//   - State goes to IDLE.
//   - exwb_valid, busy, div_fault and every exwb field go to 0; counter goes to 0.
//  Handshakes
//   - idex_ready = (state==IDLE) && (!exwb_valid || exwb_ready).
//   - Accept on idex_valid && idex_ready.
//   - exwb is stable while exwb_valid && !exwb_ready.
//   - exwb_valid drops on the handshake unless a new result loads in the same edge.
//  Single-cycle ops (latency 1, result at the next edge)
//   - 0x01 ADD a+b; 0x29 SUB a-b; 0x21 AND; 0x09 OR; 0x31 XOR.
//   - 0x89/0x8B/0x58-0x5F pass op_b.
//   - 0xF7 with modrm_reg 2: NOT a; modrm_reg 3: NEG a.
//   - Any other opcode passes op_a.
//   - All arithmetic is mod 2^XLEN; alu_ext_result=0 except for MUL/DIV.
//  State machine: IDLE -> MUL | DIV -> IDLE
//   - IDLE: accept; 0xF7/reg4 -> MUL; 0xF7/reg6 -> DIV; else load exwb directly.
//   - MUL: shift-add, one multiplier bit per cycle, XLEN cycles.
//     Loads exwb with {ext,result} = {hi,lo} of the 128-bit product. Latency XLEN+1.
//   - DIV: restoring division of {op_rdx,op_a} by op_b, XLEN cycles.
//     result=quotient, ext=remainder. Latency XLEN+1.
//   - DIV fault: if op_b==0 or op_rdx>=op_b, detected in IDLE at accept.
//     Skips iteration, latency 1, result=all-ones, ext=0, div_fault=1.
//   - busy=1 exactly while in MUL or DIV.
//   - The counter counts XLEN-1 down to 0; exwb loads when it reaches 0.
//  Boundary conditions
//   - MUL/DIV finishes while exwb is still occupied: the final write stalls in place.
//     busy stays 1 until exwb_ready, then the result loads.
//   - Multi-cycle ops are never interrupted.
//   - idex_valid is ignored while busy; upstream holds it.
//   - reset_n asserted mid-MUL/DIV discards the operation; no partial result is emitted.
//   - sim_end propagates unchanged; it carries no behaviour here.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN
//   - Defined: MUL is a single-cycle XLEN*XLEN combinational product with latency 1.
//     MUL state is unused; busy is never set by MUL.
//   - Undefined: iterative MUL as above.
//   - DIV is iterative in both builds.
// STRUCTURE
//  pkg_pipeline (shared)
//   - ID_EX and EX_WB packed typedefs.
//   - Opcode localparams: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV_ST, OP_MOV_LD, OP_GRP3.
//   - GRP3 sub-op codes: NOT=2, NEG=3, MUL=4, DIV=6.
//   - ex_state_e enum.
//  Sub-module mod_muldiv_iter
//   - Shared shift register/adder for MUL and DIV.
//   - start/op/a/b/hi inputs; done/result/ext/fault outputs.
//   - The top level owns the handshakes and the exwb register.
// TESTING
//  1. ADD a=5, b=7, exwb_ready=1 -> next cycle exwb_valid=1, alu_result=12, ext=0.
//  2. MUL a=2^63, b=4 (iterative) -> busy=1 for 64 cycles; then result=0, ext=2, div_fault=0.
//  3. DIV rdx=0, a=100, b=7 -> after 65 cycles result=14, ext=2.
//     DIV b=0 -> 1 cycle later result=all-ones, div_fault=1.
//  4. exwb_ready=0 for 10 cycles after a SUB 3-5 -> exwb held at 0xFFFF_FFFF_FFFF_FFFE.
//     idex_ready=0 throughout; consumed on the first ready cycle.
//  5. reset_n pulsed low at MUL cycle 30 -> all outputs 0 at once.
//     Next ADD 1+1 yields result=2 with no stale MUL result.
//  6. Back-to-back XOR stream with exwb_ready=1 -> one result per cycle.
//     idex_ready stays 1 and there are no bubbles.

Source files
------------

// File: rtl/pkg_pipeline.sv
// Shared pipeline definitions for the execute stage.
//   - XLEN / MD_CNT_W width constants
//   - opcode and GRP3 (0xF7) sub-op codes
//   - ID_EX / EX_WB packed bundles exchanged with decode and writeback
//   - ex_state_e execute-stage state encoding
package pkg_pipeline;

   localparam int XLEN     = 64;
   localparam int MD_CNT_W = 7;   // must be able to hold XLEN-1

   localparam logic [7:0] OP_ADD    = 8'h01;
   localparam logic [7:0] OP_SUB    = 8'h29;
   localparam logic [7:0] OP_AND    = 8'h21;
   localparam logic [7:0] OP_OR     = 8'h09;
   localparam logic [7:0] OP_XOR    = 8'h31;
   localparam logic [7:0] OP_MOV_ST = 8'h89;
   localparam logic [7:0] OP_MOV_LD = 8'h8B;
   localparam logic [7:0] OP_POP_LO = 8'h58;
   localparam logic [7:0] OP_POP_HI = 8'h5F;
   localparam logic [7:0] OP_GRP3   = 8'hF7;

   localparam logic [2:0] GRP3_NOT = 3'd2;
   localparam logic [2:0] GRP3_NEG = 3'd3;
   localparam logic [2:0] GRP3_MUL = 3'd4;
   localparam logic [2:0] GRP3_DIV = 3'd6;

   typedef enum logic [1:0] {
      EX_IDLE = 2'd0,
      EX_MUL  = 2'd1,
      EX_DIV  = 2'd2
   } ex_state_e;

   typedef struct packed {
      logic [7:0]      opcode;
      logic [3:0]      regByte;
      logic [3:0]      rmByte;
      logic [2:0]      modrm_reg;
      logic [XLEN-1:0] op_a;
      logic [XLEN-1:0] op_b;
      logic [XLEN-1:0] op_rdx;
      logic [XLEN-1:0] pc;
      logic            sim_end;
   } ID_EX;

   typedef struct packed {
      logic [XLEN-1:0] pc_contents;
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] alu_ext_result;
      logic [7:0]      ctl_opcode;
      logic [3:0]      ctl_regByte;
      logic [3:0]      ctl_rmByte;
      logic            sim_end;
   } EX_WB;

endpackage

// File: rtl/mod_execute_stage_if.sv
// Execute-stage bus bundle.
//   idex_valid/idex_ready/idex : instruction from decode
//   exwb_valid/exwb_ready/exwb : completed result to writeback
//   busy, div_fault            : status
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the sender keeps valid and its payload unchanged until that edge, and
// valid never depends on ready.
// Modports: master = decode/writeback side, slave = execute stage.
interface mod_execute_stage_if;
   import pkg_pipeline::*;

   logic idex_valid;
   logic idex_ready;
   ID_EX idex;
   logic exwb_valid;
   logic exwb_ready;
   EX_WB exwb;
   logic busy;
   logic div_fault;

   modport master (
      output idex_valid, idex, exwb_ready,
      input  idex_ready, exwb_valid, exwb, busy, div_fault
   );

   modport slave (
      input  idex_valid, idex, exwb_ready,
      output idex_ready, exwb_valid, exwb, busy, div_fault
   );

endinterface

// File: rtl/mod_muldiv_iter.sv
// Iterative unsigned multiply / restoring divide, one bit per step.
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   start_i         load operands, counter := XLEN-1
//   step_i          perform one iteration
//   op_div_i        0 = multiply a*b, 1 = divide {hi,a}/b
//   a_i, b_i, hi_i  operands (hi_i is the upper dividend half)
//   done_o          counter has reached 0: the pending step is the last one
//   result_o/ext_o  value after the pending step (low/quotient, high/remainder)
//   fault_o         combinational divide-fault check on the start operands
// hi_q/lo_q are shared: product {hi,lo} for MUL, {remainder,quotient} for DIV.
module mod_muldiv_iter
   import pkg_pipeline::*;
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start_i,
   input  logic            step_i,
   input  logic            op_div_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic [XLEN-1:0] hi_i,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [XLEN-1:0] ext_o,
   output logic            fault_o
);

   logic [XLEN-1:0]     hi_q, hi_d;
   logic [XLEN-1:0]     lo_q, lo_d;
   logic [XLEN-1:0]     b_q;
   logic                op_div_q;
   logic [MD_CNT_W-1:0] cnt_q, cnt_d;

   logic [XLEN:0]       mul_sum;
   logic [XLEN:0]       div_shift;
   logic [XLEN-1:0]     div_diff;
   logic                div_ge;

   // A quotient wider than XLEN appears exactly when the upper half >= divisor.
   assign fault_o = op_div_i && ((b_i == '0) || (hi_i >= b_i));

   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_shift = {hi_q, lo_q[XLEN-1]};
      div_ge    = (div_shift >= {1'b0, b_q});
      // remainder < divisor always holds, so the difference fits in XLEN bits
      div_diff  = div_shift[XLEN-1:0] - b_q;
      if (op_div_q) begin
         hi_d = div_ge ? div_diff : div_shift[XLEN-1:0];
         lo_d = {lo_q[XLEN-2:0], div_ge};
      end else begin
         hi_d = mul_sum[XLEN:1];
         lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end
      cnt_d = (cnt_q != '0) ? cnt_q - MD_CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         op_div_q <= 1'b0;
         cnt_q    <= '0;
      end else if (start_i) begin
         hi_q     <= op_div_i ? hi_i : '0;
         lo_q     <= a_i;
         b_q      <= b_i;
         op_div_q <= op_div_i;
         cnt_q    <= MD_CNT_W'(XLEN - 1);
      end else if (step_i) begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_d;
      end
   end

   assign done_o   = (cnt_q == '0);
   assign result_o = lo_d;
   assign ext_o    = hi_d;

endmodule

// File: rtl/mod_execute_stage.sv
// Execute stage: single-slot ALU plus iterative MUL/DIV between decode and
// writeback, results held in a registered EX_WB bundle.
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   ex_if     slave side of mod_execute_stage_if (idex in, exwb out, status)
//   state_o   current ex_state_e, for observation
// Build option: MULDIV_FAST_MUL_EN -- when defined, MUL is a single-cycle
// combinational product and the MUL state is never entered; DIV stays iterative.
module mod_execute_stage
   import pkg_pipeline::*;
(
   input  logic               clk,
   input  logic               reset_n,
   mod_execute_stage_if.slave ex_if,
   output ex_state_e          state_o
);

   ex_state_e       state_q, state_d;
   EX_WB            exwb_q, exwb_d;
   EX_WB            ctl_q, ctl_d;     // pc/control of the in-flight MUL/DIV
   logic            exwb_valid_q, exwb_valid_d;
   logic            div_fault_q, div_fault_d;

   ID_EX            idex;
   EX_WB            base;
   logic            can_load, idex_ready, accept;
   logic            is_grp3, is_div, is_mul_iter;
   logic [XLEN-1:0] alu_res, alu_ext;

   logic            md_start, md_step, md_done, md_fault;
   logic [XLEN-1:0] md_result, md_ext;

   assign idex       = ex_if.idex;
   assign can_load   = !exwb_valid_q || ex_if.exwb_ready;
   assign idex_ready = (state_q == EX_IDLE) && can_load;
   assign accept     = ex_if.idex_valid && idex_ready;
   assign is_grp3    = (idex.opcode == OP_GRP3);
   assign is_div     = is_grp3 && (idex.modrm_reg == GRP3_DIV);

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   assign fast_prod   = {{XLEN{1'b0}}, idex.op_a} * {{XLEN{1'b0}}, idex.op_b};
   assign is_mul_iter = 1'b0;
`else
   assign is_mul_iter = is_grp3 && (idex.modrm_reg == GRP3_MUL);
`endif

   always_comb begin
      alu_res = idex.op_a;
      alu_ext = '0;
      case (idex.opcode) inside
         OP_ADD: alu_res = idex.op_a + idex.op_b;
         OP_SUB: alu_res = idex.op_a - idex.op_b;
         OP_AND: alu_res = idex.op_a & idex.op_b;
         OP_OR:  alu_res = idex.op_a | idex.op_b;
         OP_XOR: alu_res = idex.op_a ^ idex.op_b;
         OP_MOV_ST, OP_MOV_LD, [OP_POP_LO:OP_POP_HI]: alu_res = idex.op_b;
         OP_GRP3: begin
            if (idex.modrm_reg == GRP3_NOT) begin
               alu_res = ~idex.op_a;
            end else if (idex.modrm_reg == GRP3_NEG) begin
               alu_res = -idex.op_a;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (idex.modrm_reg == GRP3_MUL) begin
               {alu_ext, alu_res} = fast_prod;
            end
`endif
         end
         default: alu_res = idex.op_a;
      endcase
   end

   // Control half of the result bundle; result fields are filled in on load.
   always_comb begin
      base             = '0;
      base.pc_contents = idex.pc;
      base.ctl_opcode  = idex.opcode;
      base.ctl_regByte = idex.regByte;
      base.ctl_rmByte  = idex.rmByte;
      base.sim_end     = idex.sim_end;
   end

   mod_muldiv_iter u_muldiv (
      .clk      (clk),
      .reset_n  (reset_n),
      .start_i  (md_start),
      .step_i   (md_step),
      .op_div_i (is_div),
      .a_i      (idex.op_a),
      .b_i      (idex.op_b),
      .hi_i     (idex.op_rdx),
      .done_o   (md_done),
      .result_o (md_result),
      .ext_o    (md_ext),
      .fault_o  (md_fault)
   );

   always_comb begin
      state_d      = state_q;
      exwb_d       = exwb_q;
      ctl_d        = ctl_q;
      exwb_valid_d = exwb_valid_q;
      div_fault_d  = div_fault_q;
      md_start     = 1'b0;
      md_step      = 1'b0;

      if (exwb_valid_q && ex_if.exwb_ready) begin
         exwb_valid_d = 1'b0;
         div_fault_d  = 1'b0;
      end

      case (state_q)
         EX_IDLE: begin
            if (accept) begin
               if (is_div && !md_fault) begin
                  md_start = 1'b1;
                  ctl_d    = base;
                  state_d  = EX_DIV;
               end else if (is_mul_iter) begin
                  md_start = 1'b1;
                  ctl_d    = base;
                  state_d  = EX_MUL;
               end else begin
                  exwb_d       = base;
                  exwb_valid_d = 1'b1;
                  if (is_div) begin
                     exwb_d.alu_result     = '1;
                     exwb_d.alu_ext_result = '0;
                     div_fault_d           = 1'b1;
                  end else begin
                     exwb_d.alu_result     = alu_res;
                     exwb_d.alu_ext_result = alu_ext;
                     div_fault_d           = 1'b0;
                  end
               end
            end
         end
         EX_MUL, EX_DIV: begin
            // The last iteration waits in place until the result slot is free.
            if (!md_done) begin
               md_step = 1'b1;
            end else if (can_load) begin
               md_step               = 1'b1;
               exwb_d                = ctl_q;
               exwb_d.alu_result     = md_result;
               exwb_d.alu_ext_result = md_ext;
               exwb_valid_d          = 1'b1;
               div_fault_d           = 1'b0;
               state_d               = EX_IDLE;
            end
         end
         default: state_d = EX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= EX_IDLE;
         exwb_q       <= '0;
         ctl_q        <= '0;
         exwb_valid_q <= 1'b0;
         div_fault_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         exwb_q       <= exwb_d;
         ctl_q        <= ctl_d;
         exwb_valid_q <= exwb_valid_d;
         div_fault_q  <= div_fault_d;
      end
   end

   assign ex_if.idex_ready = idex_ready;
   assign ex_if.exwb_valid = exwb_valid_q;
   assign ex_if.exwb       = exwb_q;
   assign ex_if.busy       = (state_q != EX_IDLE);
   assign ex_if.div_fault  = div_fault_q;
   assign state_o          = state_q;

endmodule

// File: tb/tb_mod_execute_stage.sv
// Bench for mod_execute_stage: directed vectors, expected results queued at
// issue time, a negedge monitor pops and compares on every exwb handshake.
module tb_mod_execute_stage;
   import pkg_pipeline::*;

   localparam int W = 1 + 8 + 1 + 3 * XLEN;   // {sim_end, opcode, fault, pc, ext, result}

   // ---------------- clock / reset ----------------
   logic      clk = 1'b0;
   logic      reset_n;
   ex_state_e state_o;

   always #5 clk = ~clk;

   mod_execute_stage_if ex_if ();

   mod_execute_stage dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ex_if   (ex_if),
      .state_o (state_o)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_got;
   int           n_checks;
   int           n_fail;
   int           pop_count;
   logic [63:0]  pc_next;

   typedef struct {
      logic [7:0]  op;
      logic [2:0]  mreg;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] e;
   } vec_t;

   vec_t vecs[11];

   function automatic logic [W-1:0] pack(input logic se, input logic [7:0] op,
                                         input logic f, input logic [63:0] pc,
                                         input logic [63:0] ext, input logic [63:0] res);
      return {se, op, f, pc, ext, res};
   endfunction

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (reset_n && ex_if.exwb_valid && ex_if.exwb_ready) begin
         mon_got = pack(ex_if.exwb.sim_end, ex_if.exwb.ctl_opcode, ex_if.div_fault,
                        ex_if.exwb.pc_contents, ex_if.exwb.alu_ext_result,
                        ex_if.exwb.alu_result);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got %0h expected none", mon_got);
         end else begin
            check("exwb", mon_got, exp_q.pop_front());
         end
         pop_count++;
      end
   end

   // ---------------- driver tasks (entered/left at posedge+1) ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [7:0] op, input logic [2:0] mreg,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] rdx,
                        input logic [63:0] er, input logic [63:0] ee, input logic ef,
                        output int waits);
      ID_EX v;
      v           = '0;
      v.opcode    = op;
      v.modrm_reg = mreg;
      v.op_a      = a;
      v.op_b      = b;
      v.op_rdx    = rdx;
      v.pc        = pc_next;
      v.regByte   = pc_next[5:2];
      v.rmByte    = ~pc_next[5:2];
      v.sim_end   = pc_next[2];
      pc_next     = pc_next + 64'd4;
      ex_if.idex       = v;
      ex_if.idex_valid = 1'b1;
      waits = 0;
      while (!ex_if.idex_ready && waits <= 300) begin
         tick();
         waits++;
      end
      if (waits > 300) begin
         n_checks++;
         n_fail++;
         $display("FAIL issue_timeout: got idex_ready=0 expected 1 within 300 cycles");
      end else begin
         exp_q.push_back(pack(v.sim_end, op, ef, v.pc, ee, er));
         tick();
      end
      ex_if.idex_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      check(name, exp_q.size(), 0);
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (ex_if.busy && n < 200) begin
         tick();
         n++;
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test expected finish before 500000");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      int w;
      int nb;
      int total_w;
      int p0;
      int exp_busy;

      n_checks  = 0;
      n_fail    = 0;
      pop_count = 0;
      pc_next   = 64'h1000;
`ifdef MULDIV_FAST_MUL_EN
      exp_busy = 0;
`else
      exp_busy = 64;
`endif

      vecs = '{
         '{8'h21, 3'd0, 64'hF0F0, 64'hFF00, 64'hF000},
         '{8'h09, 3'd0, 64'hF0F0, 64'h0F0F, 64'hFFFF},
         '{8'h31, 3'd0, 64'hFF00, 64'h0FF0, 64'hF0F0},
         '{8'h01, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0},
         '{8'h89, 3'd0, 64'd1, 64'h1234, 64'h1234},
         '{8'h8B, 3'd0, 64'd1, 64'h55, 64'h55},
         '{8'h5F, 3'd0, 64'd1, 64'h77, 64'h77},
         '{8'hF7, 3'd2, 64'd0, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF},
         '{8'hF7, 3'd3, 64'd1, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF},
         '{8'h90, 3'd0, 64'hABCD, 64'd1, 64'hABCD},
         '{8'hF7, 3'd0, 64'h42, 64'd9, 64'h42}
      };

      reset_n          = 1'b1;
      ex_if.idex_valid = 1'b0;
      ex_if.idex       = '0;
      ex_if.exwb_ready = 1'b1;
      #2;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_exwb_valid", ex_if.exwb_valid, 0);
      check("rst_busy", ex_if.busy, 0);
      check("rst_div_fault", ex_if.div_fault, 0);
      check("rst_exwb", ex_if.exwb, 0);
      check("rst_state", state_o, EX_IDLE);
      reset_n = 1'b1;
      tick();
      check("rst_idex_ready", ex_if.idex_ready, 1);

      // ADD 5+7: visible right after the accept edge
      issue(8'h01, 3'd0, 64'd5, 64'd7, 64'd0, 64'd12, 64'd0, 1'b0, w);
      check("add_latency_valid", ex_if.exwb_valid, 1);
      drain("drain_add");

      // single-cycle opcode table
      foreach (vecs[i])
         issue(vecs[i].op, vecs[i].mreg, vecs[i].a, vecs[i].b, 64'd0, vecs[i].e, 64'd0, 1'b0, w);
      drain("drain_alu");

      // MUL 2^63 * 4 -> {2, 0}
      issue(8'hF7, 3'd4, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'd0, 64'd2, 1'b0, w);
      count_busy(nb);
      check("mul_busy_cycles", nb, exp_busy);
      check("mul_done_valid", ex_if.exwb_valid, 1);
      drain("drain_mul");

      // MUL all-ones squared
      issue(8'hF7, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
            64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, w);
      drain("drain_mul_max");

      // DIV 100/7 -> q 14 r 2
      issue(8'hF7, 3'd6, 64'd100, 64'd7, 64'd0, 64'd14, 64'd2, 1'b0, w);
      count_busy(nb);
      check("div_busy_cycles", nb, 64);
      drain("drain_div");

      // DIV {1,0}/2 -> q 2^63 r 0 ; DIV {6,all-ones}/7 -> q all-ones r 6
      issue(8'hF7, 3'd6, 64'd0, 64'd2, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 1'b0, w);
      issue(8'hF7, 3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 64'd6,
            64'hFFFF_FFFF_FFFF_FFFF, 64'd6, 1'b0, w);
      drain("drain_div_wide");

      // DIV by zero: one cycle, all-ones, fault
      issue(8'hF7, 3'd6, 64'd100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, w);
      check("div0_busy", ex_if.busy, 0);
      check("div0_valid", ex_if.exwb_valid, 1);
      drain("drain_div0");

      // DIV overflow: rdx == b
      issue(8'hF7, 3'd6, 64'd3, 64'd5, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, w);
      drain("drain_div_ovf");

      // writeback stall: SUB 3-5 held for 10 cycles
      ex_if.exwb_ready = 1'b0;
      issue(8'h29, 3'd0, 64'd3, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0, w);
      ex_if.idex       = '0;
      ex_if.idex_valid = 1'b1;
      p0 = pop_count;
      for (int i = 0; i < 10; i++) begin
         check("stall_idex_ready", ex_if.idex_ready, 0);
         check("stall_valid", ex_if.exwb_valid, 1);
         check("stall_result", ex_if.exwb.alu_result, 64'hFFFF_FFFF_FFFF_FFFE);
         tick();
      end
      ex_if.idex_valid = 1'b0;
      ex_if.exwb_ready = 1'b1;
      tick();
      check("stall_consumed", pop_count - p0, 1);
      check("stall_queue", exp_q.size(), 0);

      // MUL completing into a stalled writeback holds its result
      ex_if.exwb_ready = 1'b0;
      issue(8'hF7, 3'd4, 64'd3, 64'd5, 64'd0, 64'd15, 64'd0, 1'b0, w);
      repeat (70) tick();
      check("mul_hold_busy", ex_if.busy, 0);
      check("mul_hold_valid", ex_if.exwb_valid, 1);
      check("mul_hold_result", ex_if.exwb.alu_result, 64'd15);
      ex_if.exwb_ready = 1'b1;
      drain("drain_mul_hold");

      // reset in the middle of a MUL
      issue(8'hF7, 3'd4, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'd0, 64'd2, 1'b0, w);
      repeat (30) tick();
      exp_q.delete();
      reset_n = 1'b0;
      #1;
      check("midrst_valid", ex_if.exwb_valid, 0);
      check("midrst_busy", ex_if.busy, 0);
      check("midrst_fault", ex_if.div_fault, 0);
      check("midrst_exwb", ex_if.exwb, 0);
      check("midrst_state", state_o, EX_IDLE);
      tick();
      reset_n = 1'b1;
      tick();
      issue(8'h01, 3'd0, 64'd1, 64'd1, 64'd0, 64'd2, 64'd0, 1'b0, w);
      drain("drain_after_rst");
      repeat (70) tick();

      // back-to-back XOR stream
      total_w = 0;
      p0      = pop_count;
      for (int i = 0; i < 8; i++) begin
         issue(8'h31, 3'd0, 64'(i * 3 + 1), 64'h00FF, 64'd0, 64'(i * 3 + 1) ^ 64'h00FF,
               64'd0, 1'b0, w);
         total_w += w;
      end
      check("stream_waits", total_w, 0);
      tick();
      check("stream_results", pop_count - p0, 8);
      drain("drain_stream");

      check("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
